// File: rtl/posit_pkg.sv
// Shared constants and types for the posit<32,2> operand decoder.
package posit_pkg;

    localparam int POSIT_N   = 32;
    localparam int POSIT_ES  = 2;
    localparam int SCALE_W   = 9;
    localparam int FRAC_W    = 28;
    localparam int M_W       = 5;
    localparam int MAX_SCALE = 120;

    localparam logic [POSIT_N-1:0] NAR_WORD  = 32'h8000_0000;
    localparam logic [POSIT_N-1:0] ZERO_WORD = 32'h0000_0000;

    // Front-end view of an operand: special flags plus sign/magnitude.
    typedef struct packed {
        logic                 zero;
        logic                 nar;
        logic                 sign;
        logic [POSIT_N-2:0]   mag;
    } front_t;

endpackage

// File: rtl/posit_regime_cnt.sv
// Regime run-length counter: number of identical leading bits of the posit body.
module posit_regime_cnt
    import posit_pkg::*;
(
    input  logic [POSIT_N-2:0] bits,
    output logic [M_W-1:0]     m
);

    logic found;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        m     = M_W'(POSIT_N - 1);
        found = 1'b0;
        for (int i = POSIT_N - 2; i >= 0; i--) begin
            if (!found && bits[i] != bits[POSIT_N-2]) begin
                m     = M_W'(POSIT_N - 2 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/posit_decode_pipe.sv
// posit<32,2> operand decoder feeding the exponent adder; POSIT_DEC_PIPE2_EN selects the
// 2-stage pipeline, otherwise a single registered stage with the same handshake.
module posit_decode_pipe
    import posit_pkg::*;
#(
    parameter int N  = POSIT_N,
    parameter int ES = POSIT_ES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       posit_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sign,
    output logic [SCALE_W-1:0] scale,
    output logic [FRAC_W-1:0]  frac,
    output logic               ZERO,
    output logic               NAR
);

    localparam int MW     = N - 1;
    localparam int BODY_W = ES + FRAC_W - 1;
    localparam logic signed [SCALE_W-1:0] SCALE_HI = SCALE_W'(MAX_SCALE);
    localparam logic signed [SCALE_W-1:0] SCALE_LO = SCALE_W'(-MAX_SCALE);

    front_t front_d;
    front_t dec_in;
    logic   dec_valid;
    logic   adv;

    always_comb begin
        front_d.zero = (posit_in == ZERO_WORD);
        front_d.nar  = (posit_in == NAR_WORD);
        front_d.sign = posit_in[N-1];
        front_d.mag  = MW'(posit_in[N-1] ? (~posit_in + 1'b1) : posit_in);
    end

    assign adv = !out_valid || out_ready;

`ifdef POSIT_DEC_PIPE2_EN
    front_t s1_q;
    logic   s1_valid;

    assign in_ready = !s1_valid || adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            s1_valid <= in_valid;
            if (in_valid)
                s1_q <= front_d;
        end
    end

    assign dec_valid = s1_valid;
    assign dec_in    = s1_q;
`else
    assign in_ready  = adv;
    assign dec_valid = in_valid;
    assign dec_in    = front_d;
`endif

    logic [M_W-1:0]            run_len;
    logic                      regime_one;
    logic [5:0]                shamt;
    logic [BODY_W-1:0]         body;
    logic signed [M_W+1:0]     m_s;
    logic signed [M_W+1:0]     k;
    logic signed [SCALE_W-1:0] scale_raw;
    logic signed [SCALE_W-1:0] scale_d;
    logic [FRAC_W-1:0]         frac_d;
    logic                      special;

    posit_regime_cnt u_regime (
        .bits (dec_in.mag),
        .m    (run_len)
    );

    always_comb begin
        regime_one = dec_in.mag[MW-1];
        // Drop the regime run and its terminating bit; the rest is exponent then fraction.
        shamt      = {1'b0, run_len} + 6'd1;
        body       = BODY_W'((dec_in.mag << shamt) >> (MW - BODY_W));
        m_s        = signed'({2'b00, run_len});
        k          = regime_one ? (m_s - 7'sd1) : -m_s;
        scale_raw  = {k, body[BODY_W-1 -: ES]};
        scale_d    = scale_raw;
        if (scale_raw > SCALE_HI)
            scale_d = SCALE_HI;
        else if (scale_raw < SCALE_LO)
            scale_d = SCALE_LO;
        frac_d     = {1'b1, body[FRAC_W-2:0]};
        special    = dec_in.zero || dec_in.nar;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sign      <= 1'b0;
            scale     <= '0;
            frac      <= '0;
            ZERO      <= 1'b0;
            NAR       <= 1'b0;
        end else if (adv) begin
            out_valid <= dec_valid;
            if (dec_valid) begin
                ZERO  <= dec_in.zero;
                NAR   <= dec_in.nar;
                sign  <= special ? 1'b0 : dec_in.sign;
                scale <= special ? '0 : scale_d;
                frac  <= special ? '0 : frac_d;
            end
        end
    end

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Self-checking bench for posit_decode_pipe: directed vectors, backpressured stream,
// mid-flight reset and random traffic against a bit-walking reference model.
module tb_posit_decode_pipe;

`ifdef POSIT_DEC_PIPE2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] posit_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        sign;
    logic [8:0]  scale;
    logic [27:0] frac;
    logic        ZERO;
    logic        NAR;

    always #5 clk = ~clk;

    posit_decode_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .posit_in  (posit_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .scale     (scale),
        .frac      (frac),
        .ZERO      (ZERO),
        .NAR       (NAR)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Walks the operand bit by bit: regime run, terminator, ES exponent bits, fraction.
    function automatic logic [39:0] model(input logic [31:0] x);
        logic [31:0] v;
        logic [27:0] f;
        logic        r;
        int          i, m, e, k, sc;
        if (x == 32'h0000_0000) return {2'b10, 38'd0};
        if (x == 32'h8000_0000) return {2'b01, 38'd0};
        v = x[31] ? (~x + 32'd1) : x;
        r = v[30];
        i = 30;
        m = 0;
        while (i >= 0 && v[i] == r) begin
            m++;
            i--;
        end
        i--;
        e = 0;
        for (int j = 0; j < 2; j++) begin
            e = 2 * e + ((i >= 0) ? int'(v[i]) : 0);
            i--;
        end
        f = 28'd1;
        for (int j = 0; j < 27; j++) begin
            f = {f[26:0], (i >= 0) ? v[i] : 1'b0};
            i--;
        end
        k  = r ? m - 1 : -m;
        sc = 4 * k + e;
        if (sc > 120)  sc = 120;
        if (sc < -120) sc = -120;
        return {2'b00, x[31], 9'(sc), f};
    endfunction

    wire [39:0] out_word = {ZERO, NAR, sign, scale, frac};

    logic [39:0] exp_q[$];
    int          n_acc = 0;
    int          n_out = 0;
    logic        stalled = 1'b0;
    logic [39:0] held = '0;

    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_fields", 64'(out_word), 64'(held));
            end
            check("in_ready", 64'(in_ready), 64'(!(exp_q.size() == DEPTH && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check("unexpected_out", 64'(out_valid), 64'd0);
                else
                    check("data", 64'(out_word), 64'(exp_q.pop_front()));
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(posit_in));
                n_acc++;
            end
            stalled = out_valid && !out_ready;
            held    = out_word;
        end
    end

    function automatic logic [31:0] rand_posit();
        logic [31:0] specials [8] = '{32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1,
                                      32'hFFFF_FFFF, 32'h8000_0001, 32'h4000_0000, 32'hC000_0000};
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0:       v = $urandom >> $urandom_range(0, 31);
            1:       v = 32'h7FFF_FFFF & ~($urandom >> $urandom_range(1, 31));
            2:       v = specials[$urandom_range(0, 7)];
            default: v = $urandom;
        endcase
        if ($urandom_range(0, 3) == 0) v = ~v + 32'd1;
        return v;
    endfunction

    task automatic drain();
        int c = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (exp_q.size() != 0 && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic directed(input string tag, input logic [31:0] x, input logic [39:0] exp);
        int lat = 0;
        drain();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        posit_in = x;
        @(negedge clk);
        do begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 10);
        check({tag, "_latency"}, 64'(lat), 64'(DEPTH));
        check({tag, "_fields"}, 64'(out_word), 64'(exp));
    endtask

    task automatic run_random(input int target);
        int base = n_acc;
        int cyc  = 0;
        while (cyc < 20000) begin
            @(posedge clk);
            #1;
            if (n_acc - base >= target) break;
            in_valid  = ($urandom_range(0, 9) < 7);
            posit_in  = rand_posit();
            out_ready = ($urandom_range(0, 9) < 6);
            cyc++;
        end
        in_valid = 1'b0;
        check("random_accepted", 64'(n_acc - base >= target), 64'd1);
    endtask

    task automatic run_stream();
        logic [31:0] stream [8];
        int base, obase, cyc;
        drain();
        for (int i = 0; i < 8; i++) stream[i] = ($urandom & 32'hFFFF_FF00) | 32'(i);
        base      = n_acc;
        obase     = n_out;
        cyc       = 0;
        out_ready = 1'b1;
        while (n_out - obase < 8 && cyc < 200) begin
            @(posedge clk);
            #1;
            out_ready = ~out_ready;
            if (n_acc - base < 8) begin
                in_valid = 1'b1;
                posit_in = stream[n_acc - base];
            end else begin
                in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        drain();
        check("stream_accepted", 64'(n_acc - base), 64'd8);
        check("stream_emitted", 64'(n_out - obase), 64'd8);
    endtask

    task automatic run_reset_midflight();
        int n0;
        drain();
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        posit_in = 32'h4000_0000;
        @(posedge clk);
        #1;
        posit_in = 32'h4800_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_fields", 64'(out_word), 64'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        n0        = n_out;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_stale", 64'(n_out), 64'(n0));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_fields", 64'(out_word), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        directed("one",     32'h4000_0000, {3'b000, 9'd0,      28'h800_0000});
        directed("neg_one", 32'hC000_0000, {3'b001, 9'd0,      28'h800_0000});
        directed("two",     32'h4800_0000, {3'b000, 9'd1,      28'h800_0000});
        directed("maxpos",  32'h7FFF_FFFF, {3'b000, 9'd120,    28'h800_0000});
        directed("minpos",  32'h0000_0001, {3'b000, 9'h188,    28'h800_0000});
        directed("zero",    32'h0000_0000, {3'b100, 9'd0,      28'h0});
        directed("nar",     32'h8000_0000, {3'b010, 9'd0,      28'h0});

        run_stream();
        run_random(300);
        drain();
        run_reset_midflight();
        run_random(100);
        drain();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
